// File: rtl/mem_port_if.sv
// mem_port_if: fetch, load/store and byte-RAM signals shared by the arbiter and its environment
interface mem_port_if #(parameter int ADDR_W = 17);
  logic              if_req_i;
  logic [31:0]       if_addr_i;
  logic              if_flush_i;
  logic              if_done_o;
  logic [31:0]       if_data_o;
  logic              mem_req_i;
  logic              mem_we_i;
  logic [1:0]        mem_size_i;
  logic [31:0]       mem_addr_i;
  logic [31:0]       mem_wdata_i;
  logic              mem_done_o;
  logic [31:0]       mem_rdata_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_we_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i;
  logic              stallreq_o;
  modport master (
    output if_req_i, if_addr_i, if_flush_i, mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i, ram_din_i,
    input  if_done_o, if_data_o, mem_done_o, mem_rdata_o, ram_addr_o, ram_we_o, ram_dout_o, stallreq_o
  );
  modport slave (
    input  if_req_i, if_addr_i, if_flush_i, mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i, ram_din_i,
    output if_done_o, if_data_o, mem_done_o, mem_rdata_o, ram_addr_o, ram_we_o, ram_dout_o, stallreq_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide RAM port between fetch and load/store, MEM first
module mem_port_arbiter #(parameter int ADDR_W = 17) (
  input logic      clk,
  input logic      rst,
  mem_port_if.slave bus
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  state_t state, state_n;
  logic if_pend, mem_pend, owner_mem, we_q, m_we_q, e_we;
  logic [ADDR_W-1:0] if_addr_q, m_addr_q, addr_q, e_addr;
  logic [31:0] m_wdata_q, wdata_q, buf_q, merged, e_wdata;
  logic [1:0] m_size_q, e_size, cap;
  logic [2:0] cnt, nb, e_nb;
  logic [7:0] wbyte;
  logic mem_busy, if_busy, acc_mem, acc_if, want_mem, want_if, grant_mem, grant_if, abort, last_w, last_r;
  logic unused;
  assign unused = ^{bus.if_addr_i[31:ADDR_W], bus.mem_addr_i[31:ADDR_W]};
  assign bus.if_done_o = state == DONE && !owner_mem;
  assign bus.mem_done_o = state == DONE && owner_mem;
  assign bus.stallreq_o = if_pend || mem_pend || state != IDLE;
  // request acceptance, grant selection and byte steering
  always_comb begin
    mem_busy = state != IDLE && owner_mem;
    if_busy = state != IDLE && !owner_mem;
    acc_mem = bus.mem_req_i && !mem_pend && !mem_busy;
    acc_if = bus.if_req_i && ((!if_pend && !if_busy) || bus.if_flush_i);
    want_mem = mem_pend || acc_mem;
    want_if = (if_pend && !bus.if_flush_i) || acc_if;
    grant_mem = state == IDLE && want_mem;
    grant_if = state == IDLE && !want_mem && want_if;
    e_we = grant_mem && (acc_mem ? bus.mem_we_i : m_we_q);
    e_size = grant_mem ? (acc_mem ? bus.mem_size_i : m_size_q) : 2'd2;
    e_addr = grant_mem ? (acc_mem ? bus.mem_addr_i[ADDR_W-1:0] : m_addr_q)
                       : (acc_if ? bus.if_addr_i[ADDR_W-1:0] : if_addr_q);
    e_wdata = acc_mem ? bus.mem_wdata_i : m_wdata_q;
    e_nb = e_size == 2'd0 ? 3'd1 : e_size == 2'd1 ? 3'd2 : 3'd4;
    last_w = cnt == nb - 3'd1;
    last_r = cnt == nb;
    abort = state == XFER && !owner_mem && bus.if_flush_i;
    cap = 2'(cnt - 3'd1);
    merged = buf_q | ({24'd0, bus.ram_din_i} << {cap, 3'b000});
    wbyte = 8'(wdata_q >> {cnt[1:0] + 2'd1, 3'b000});
  end
  // next state: reads stay in XFER one extra cycle to capture the last byte
  always_comb begin
    state_n = state == IDLE ? ((grant_mem || grant_if) ? XFER : IDLE)
            : state == XFER ? (abort ? IDLE : (we_q ? last_w : last_r) ? DONE : XFER)
            : IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // pending flags, request latches, RAM port registers and read assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      if_pend <= 1'b0;
      mem_pend <= 1'b0;
      owner_mem <= 1'b0;
      we_q <= 1'b0;
      m_we_q <= 1'b0;
      m_size_q <= 2'd0;
      if_addr_q <= '0;
      m_addr_q <= '0;
      addr_q <= '0;
      m_wdata_q <= 32'd0;
      wdata_q <= 32'd0;
      buf_q <= 32'd0;
      cnt <= 3'd0;
      nb <= 3'd0;
      bus.ram_addr_o <= '0;
      bus.ram_we_o <= 1'b0;
      bus.ram_dout_o <= 8'd0;
      bus.if_data_o <= 32'd0;
      bus.mem_rdata_o <= 32'd0;
    end else begin
      if_pend <= grant_if ? 1'b0 : acc_if ? 1'b1 : bus.if_flush_i ? 1'b0 : if_pend;
      mem_pend <= grant_mem ? 1'b0 : acc_mem ? 1'b1 : mem_pend;
      if (acc_if) if_addr_q <= bus.if_addr_i[ADDR_W-1:0];
      if (acc_mem) begin
        m_addr_q <= bus.mem_addr_i[ADDR_W-1:0];
        m_we_q <= bus.mem_we_i;
        m_size_q <= bus.mem_size_i;
        m_wdata_q <= bus.mem_wdata_i;
      end
      if (grant_mem || grant_if) begin
        owner_mem <= grant_mem;
        we_q <= e_we;
        nb <= e_nb;
        addr_q <= e_addr;
        wdata_q <= e_wdata;
        cnt <= 3'd0;
        buf_q <= 32'd0;
        bus.ram_addr_o <= e_addr;
        bus.ram_we_o <= e_we;
        bus.ram_dout_o <= e_wdata[7:0];
      end else if (state == XFER && !abort) begin
        cnt <= cnt + 3'd1;
        if (we_q) begin
          bus.ram_we_o <= !last_w;
          if (!last_w) begin
            bus.ram_addr_o <= addr_q + ADDR_W'(cnt) + ADDR_W'(1);
            bus.ram_dout_o <= wbyte;
          end
        end else begin
          if (cnt != 3'd0) buf_q <= merged;
          if (cnt < nb - 3'd1) bus.ram_addr_o <= addr_q + ADDR_W'(cnt) + ADDR_W'(1);
          if (last_r && owner_mem) bus.mem_rdata_o <= merged;
          if (last_r && !owner_mem) bus.if_data_o <= merged;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus multi-cycle corner sequences
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [7:0] ram [0:131071];
  mem_port_if #(.ADDR_W(17)) b();
  mem_port_arbiter #(.ADDR_W(17)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (b.ram_we_o) ram[b.ram_addr_o] <= b.ram_dout_o;
    b.ram_din_i <= ram[b.ram_addr_o];
  end
  typedef struct {
    logic        is_mem;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          done_at;
    int          flush_at;
  } vec_t;
  vec_t vt [12];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", nm, got, exp, $time);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    b.if_req_i = 1'b0;
    b.if_addr_i = 32'd0;
    b.if_flush_i = 1'b0;
    b.mem_req_i = 1'b0;
    b.mem_we_i = 1'b0;
    b.mem_size_i = 2'd0;
    b.mem_addr_i = 32'd0;
    b.mem_wdata_i = 32'd0;
  endtask
  initial begin
    int n, dc, dn, odn, md, id;
    logic [31:0] dd, mr, idat;
    logic d, od;
    idle_inputs();
    for (int i = 0; i < 131072; i++) ram[i] = 8'h00;
    ram[4] = 8'h13; ram[5] = 8'h00; ram[6] = 8'h50; ram[7] = 8'h00;
    ram[8] = 8'h93; ram[9] = 8'h00; ram[10] = 8'h10; ram[11] = 8'h00;
    ram[64] = 8'h01; ram[65] = 8'h02; ram[66] = 8'h03; ram[67] = 8'h04;
    ram[17'h203] = 8'h80; ram[17'h1ffff] = 8'h34; ram[0] = 8'h12; ram[17'h300] = 8'h11;
    //             mem   we    size  addr          wdata         exp           done flush
    vt[0]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0004, 32'h0,        32'h0050_0013, 6, -1};
    vt[1]  = '{1'b1, 1'b1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        5, -1};
    vt[2]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 6, -1};
    vt[3]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0203, 32'h0,        32'h0000_0080, 3, -1};
    vt[4]  = '{1'b1, 1'b0, 2'd1, 32'h0001_FFFF, 32'h0,        32'h0000_1234, 4, -1};
    vt[5]  = '{1'b1, 1'b1, 2'd0, 32'h0000_0301, 32'hFFFF_FFAA, 32'h0,        2, -1};
    vt[6]  = '{1'b1, 1'b1, 2'd1, 32'h0000_0302, 32'h7777_5566, 32'h0,        3, -1};
    vt[7]  = '{1'b1, 1'b0, 2'd3, 32'h0000_0300, 32'h0,        32'h5566_AA11, 6, -1};
    vt[8]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 6, 2};
    vt[9]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0102, 32'h0,        32'h0000_00AD, 3, -1};
    vt[10] = '{1'b1, 1'b0, 2'd1, 32'h0000_0101, 32'h0,        32'h0000_ADBE, 4, -1};
    vt[11] = '{1'b0, 1'b0, 2'd2, 32'h0000_0040, 32'h0,        32'h0403_0201, 6, -1};
    nxt();
    nxt();
    @(negedge clk);
    chk("rst_if_done", 32'(b.if_done_o), 32'd0);
    chk("rst_mem_done", 32'(b.mem_done_o), 32'd0);
    chk("rst_ram_we", 32'(b.ram_we_o), 32'd0);
    chk("rst_ram_addr", 32'(b.ram_addr_o), 32'd0);
    chk("rst_ram_dout", 32'(b.ram_dout_o), 32'd0);
    chk("rst_stall", 32'(b.stallreq_o), 32'd0);
    chk("rst_if_data", b.if_data_o, 32'd0);
    chk("rst_mem_rdata", b.mem_rdata_o, 32'd0);
    rst = 1'b0;
    nxt();
    for (int i = 0; i < 12; i++) begin
      n = vt[i].size == 2'd0 ? 1 : vt[i].size == 2'd1 ? 2 : 4;
      dc = -1; dn = 0; odn = 0; dd = 32'd0;
      for (int c = 0; c < 12; c++) begin
        b.mem_req_i = vt[i].is_mem && c == 0;
        b.if_req_i = !vt[i].is_mem && c == 0;
        b.mem_we_i = vt[i].we;
        b.mem_size_i = vt[i].size;
        b.mem_addr_i = vt[i].addr;
        b.if_addr_i = vt[i].addr;
        b.mem_wdata_i = vt[i].wdata;
        b.if_flush_i = c == vt[i].flush_at;
        @(negedge clk);
        if (c >= 1 && c <= n) chk("ram_addr", 32'(b.ram_addr_o), (vt[i].addr + 32'(c - 1)) & 32'h1ffff);
        if (c >= 1 && c <= vt[i].done_at) chk("ram_we", 32'(b.ram_we_o), 32'(vt[i].we && c <= n));
        if (vt[i].we && c >= 1 && c <= n) chk("ram_dout", 32'(b.ram_dout_o), (vt[i].wdata >> (8 * (c - 1))) & 32'hff);
        if (c >= 1) chk("stall", 32'(b.stallreq_o), 32'(c <= vt[i].done_at));
        d = vt[i].is_mem ? b.mem_done_o : b.if_done_o;
        od = vt[i].is_mem ? b.if_done_o : b.mem_done_o;
        if (d) begin
          dn++;
          if (dc < 0) begin
            dc = c;
            dd = vt[i].is_mem ? b.mem_rdata_o : b.if_data_o;
          end
        end
        if (od) odn++;
        nxt();
      end
      idle_inputs();
      chk("done_cycle", 32'(dc), 32'(vt[i].done_at));
      chk("done_count", 32'(dn), 32'd1);
      chk("other_done", 32'(odn), 32'd0);
      if (!vt[i].we) chk("rdata", dd, vt[i].exp);
    end
    // simultaneous fetch and byte load: MEM first, IF granted in the IDLE after DONE
    md = -1; id = -1; mr = 32'd0; idat = 32'd0;
    for (int c = 0; c < 14; c++) begin
      b.if_req_i = c == 0;
      b.if_addr_i = 32'h8;
      b.mem_req_i = c == 0;
      b.mem_we_i = 1'b0;
      b.mem_size_i = 2'd0;
      b.mem_addr_i = 32'h203;
      @(negedge clk);
      if (b.mem_done_o && md < 0) begin md = c; mr = b.mem_rdata_o; end
      if (b.if_done_o && id < 0) begin id = c; idat = b.if_data_o; end
      if (c == 4) chk("sim_stall_pend", 32'(b.stallreq_o), 32'd1);
      if (c == 5) chk("sim_if_addr", 32'(b.ram_addr_o), 32'h8);
      nxt();
    end
    idle_inputs();
    chk("sim_mem_done", 32'(md), 32'd3);
    chk("sim_mem_rdata", mr, 32'h80);
    chk("sim_if_done", 32'(id), 32'd10);
    chk("sim_if_data", idat, 32'h0010_0093);
    // flush aborts an in-flight fetch; a new fetch follows in the next cycle
    id = -1; dn = 0; idat = 32'd0;
    for (int c = 0; c < 12; c++) begin
      b.if_req_i = c == 0 || c == 3;
      b.if_addr_i = c == 3 ? 32'h40 : 32'h8;
      b.if_flush_i = c == 2;
      @(negedge clk);
      if (c == 3) chk("flush_addr_hold", 32'(b.ram_addr_o), 32'h9);
      if (c == 3) chk("flush_we", 32'(b.ram_we_o), 32'd0);
      if (b.if_done_o) begin dn++; if (id < 0) begin id = c; idat = b.if_data_o; end end
      nxt();
    end
    idle_inputs();
    chk("flush_done_cycle", 32'(id), 32'd9);
    chk("flush_done_count", 32'(dn), 32'd1);
    chk("flush_data", idat, 32'h0403_0201);
    // flush and request in the same cycle: request survives as the new pending fetch
    id = -1; dn = 0; idat = 32'd0;
    for (int c = 0; c < 12; c++) begin
      b.if_req_i = c == 0 || c == 2;
      b.if_addr_i = c == 2 ? 32'h40 : 32'h4;
      b.if_flush_i = c == 2;
      @(negedge clk);
      if (c == 3) chk("flreq_stall", 32'(b.stallreq_o), 32'd1);
      if (b.if_done_o) begin dn++; if (id < 0) begin id = c; idat = b.if_data_o; end end
      nxt();
    end
    idle_inputs();
    chk("flreq_done_cycle", 32'(id), 32'd9);
    chk("flreq_done_count", 32'(dn), 32'd1);
    chk("flreq_data", idat, 32'h0403_0201);
    // reset in cycle 3 of a word store with a fetch pending
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      b.mem_req_i = c == 0;
      b.mem_we_i = 1'b1;
      b.mem_size_i = 2'd2;
      b.mem_addr_i = 32'h500;
      b.mem_wdata_i = 32'h1122_3344;
      b.if_req_i = c == 1;
      b.if_addr_i = 32'h4;
      rst = c == 3;
      @(negedge clk);
      if (c == 4) begin
        chk("rst_mid_we", 32'(b.ram_we_o), 32'd0);
        chk("rst_mid_stall", 32'(b.stallreq_o), 32'd0);
        chk("rst_mid_addr", 32'(b.ram_addr_o), 32'd0);
      end
      if (c >= 4 && (b.mem_done_o || b.if_done_o)) dn++;
      nxt();
    end
    idle_inputs();
    rst = 1'b0;
    chk("rst_mid_no_done", 32'(dn), 32'd0);
    chk("rst_mid_b0", 32'(ram[17'h500]), 32'h44);
    chk("rst_mid_b2", 32'(ram[17'h502]), 32'h22);
    chk("rst_mid_b3", 32'(ram[17'h503]), 32'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
